// File: rtl/writeback_arbiter.sv
// Writeback stage: round-robin selection of one X__W message per cycle from the
// execute pipes, one register stage, then register-file write and completion.
module writeback_arbiter #(
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_seq_num_bits = 5,
  parameter int p_num_pipes    = 2
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [p_num_pipes-1:0]                i_x_val,
  output logic [p_num_pipes-1:0]                o_x_rdy,
  input  logic [p_num_pipes*p_addr_bits-1:0]    i_x_pc,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] i_x_seq_num,
  input  logic [p_num_pipes*5-1:0]              i_x_waddr,
  input  logic [p_num_pipes*p_data_bits-1:0]    i_x_wdata,
  input  logic [p_num_pipes-1:0]                i_x_wen,
  output logic [4:0]                            o_rf_waddr,
  output logic [p_data_bits-1:0]                o_rf_wdata,
  output logic                                  o_rf_wen,
  output logic                                  o_cmp_val,
  output logic [p_addr_bits-1:0]                o_cmp_pc,
  output logic [p_seq_num_bits-1:0]             o_cmp_seq_num
);

  localparam int LP_PW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic [LP_PW-1:0]          r_ptr;
  logic [LP_PW-1:0]          w_ptr_acc;
  logic [LP_PW-1:0]          w_ptr_nxt;
  logic [2*p_num_pipes-1:0]  w_dbl;
  logic [2*p_num_pipes-1:0]  w_gnt_dbl;
  logic [p_num_pipes-1:0]    w_rot;
  logic [p_num_pipes-1:0]    w_onehot;
  logic [p_num_pipes-1:0]    w_grant;
  logic                      w_any;

  logic [p_addr_bits-1:0]    w_pc;
  logic [p_seq_num_bits-1:0] w_seq;
  logic [4:0]                w_waddr;
  logic [p_data_bits-1:0]    w_wdata;
  logic                      w_wen;

  logic                      r_wb_val;
  logic                      r_rf_wen;
  logic [p_addr_bits-1:0]    r_pc;
  logic [p_seq_num_bits-1:0] r_seq;
  logic [4:0]                r_waddr;
  logic [p_data_bits-1:0]    r_wdata;

  // Rotate valids so ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    w_dbl    = {i_x_val, i_x_val} >> r_ptr;
    w_rot    = w_dbl[p_num_pipes-1:0];
    w_onehot = '0;
    for (int k = p_num_pipes - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_onehot    = '0;
        w_onehot[k] = 1'b1;
      end else begin
        w_onehot = w_onehot;
      end
    end
    w_gnt_dbl = {{p_num_pipes{1'b0}}, w_onehot} << r_ptr;
    if (i_rst) begin
      w_grant = '0;
    end else begin
      w_grant = w_gnt_dbl[2*p_num_pipes-1:p_num_pipes] | w_gnt_dbl[p_num_pipes-1:0];
    end
    w_any = |w_grant;
  end

  assign o_x_rdy = w_grant;

  // One-hot AND-OR mux of the granted pipe's fields and its successor pointer.
  always_comb begin
    w_pc      = '0;
    w_seq     = '0;
    w_waddr   = 5'd0;
    w_wdata   = '0;
    w_wen     = 1'b0;
    w_ptr_acc = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      w_pc      = w_pc    | ({p_addr_bits{w_grant[i]}}    & i_x_pc[i*p_addr_bits +: p_addr_bits]);
      w_seq     = w_seq   | ({p_seq_num_bits{w_grant[i]}} & i_x_seq_num[i*p_seq_num_bits +: p_seq_num_bits]);
      w_waddr   = w_waddr | ({5{w_grant[i]}}              & i_x_waddr[i*5 +: 5]);
      w_wdata   = w_wdata | ({p_data_bits{w_grant[i]}}    & i_x_wdata[i*p_data_bits +: p_data_bits]);
      w_wen     = w_wen   | (w_grant[i] & i_x_wen[i]);
      w_ptr_acc = w_ptr_acc | ({LP_PW{w_grant[i]}} & LP_PW'((i + 1) % p_num_pipes));
    end
    w_ptr_nxt = w_any ? w_ptr_acc : r_ptr;
  end

  // Stage register; x0 suppression is folded into the registered write strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr    <= '0;
      r_wb_val <= 1'b0;
      r_rf_wen <= 1'b0;
      r_pc     <= '0;
      r_seq    <= '0;
      r_waddr  <= 5'd0;
      r_wdata  <= '0;
    end else begin
      r_ptr    <= w_ptr_nxt;
      r_wb_val <= w_any;
      r_rf_wen <= w_any & w_wen & (w_waddr != 5'd0);
      if (w_any) begin
        r_pc    <= w_pc;
        r_seq   <= w_seq;
        r_waddr <= w_waddr;
        r_wdata <= w_wdata;
      end else begin
        r_pc    <= r_pc;
        r_seq   <= r_seq;
        r_waddr <= r_waddr;
        r_wdata <= r_wdata;
      end
    end
  end

  assign o_rf_waddr    = r_waddr;
  assign o_rf_wdata    = r_wdata;
  assign o_rf_wen      = r_rf_wen;
  assign o_cmp_val     = r_wb_val;
  assign o_cmp_pc      = r_pc;
  assign o_cmp_seq_num = r_seq;

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly downstream of the execute units (ALU, Multiplier, and others).
- Accepts X__W messages from p_num_pipes execute pipes and selects one per cycle with a round-robin arbiter.
- Registers the selected message for one cycle, then drives the register-file write port and a completion pulse to the commit/scoreboard logic.

Parameters:
- p_addr_bits, 32, width of pc.
- p_data_bits, 32, width of wdata.
- p_seq_num_bits, 5, width of seq_num.
- p_num_pipes, 2, number of execute pipes arbitrated (legal range 1..8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- x_val  in  p_num_pipes  per-pipe X__W valid.
- x_rdy  out  p_num_pipes  per-pipe X__W ready; one-hot or zero.
- x_pc  in  p_num_pipes*p_addr_bits  per-pipe pc; pipe i at slice i.
- x_seq_num  in  p_num_pipes*p_seq_num_bits  per-pipe seq_num.
- x_waddr  in  p_num_pipes*5  per-pipe destination register.
- x_wdata  in  p_num_pipes*p_data_bits  per-pipe result.
- x_wen  in  p_num_pipes  per-pipe write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  p_data_bits  register-file write data.
- rf_wen  out  1  register-file write strobe.
- cmp_val  out  1  completion pulse, one per retired message.
- cmp_pc  out  p_addr_bits  completed pc.
- cmp_seq_num  out  p_seq_num_bits  completed seq_num.

Behaviour:
- Reset, asynchronous, active-high:
  - wb_val=0 and all captured fields=0.
  - ptr=0.
  - Outputs while in reset: rf_wen=0, cmp_val=0, rf_waddr=0, rf_wdata=0, cmp_pc=0, cmp_seq_num=0.
  - x_rdy=0 while rst is asserted.
- Handshake:
  - A transfer on pipe i occurs in cycle t when x_val[i] and x_rdy[i] are both high at the rising edge.
  - x_rdy is combinational from x_val and ptr.
  - x_rdy[i]=1 only for the granted pipe; there is no downstream backpressure, so the stage accepts one message every cycle.
- Arbitration:
  - Search order is ptr, ptr+1, ..., wrapping mod p_num_pipes; the first pipe with x_val high is granted.
  - On a grant to pipe g: ptr <= (g+1) mod p_num_pipes.
  - With no valid input, ptr holds.
  - With p_num_pipes=1, x_rdy = x_val while out of reset.
- Stage register:
  - On a grant, capture pc, seq_num, waddr, wdata and wen of pipe g, and set wb_val=1.
  - With no grant, wb_val <= 0.
- Latency: a message transferred at edge t appears on rf_* and cmp_* during the cycle following edge t, i.e. 1 cycle. Throughput is 1 message per cycle total.
- Outputs, all driven from the stage register:
  - rf_wen = wb_val & wen & (waddr != 0). Writes to x0 are suppressed.
  - cmp_val = wb_val. A completion is issued even when wen=0 or waddr=0.
  - rf_waddr, rf_wdata, cmp_pc and cmp_seq_num show the captured fields. They hold their last value when wb_val=0.
- Simultaneous valids: exactly one pipe is granted; the others hold val and data stable (valid/ready protocol) until granted.
- Starvation bound: a continuously valid pipe is granted within p_num_pipes cycles.
- Reset mid-operation: an in-flight stage-register entry is dropped. No rf write and no cmp pulse occur for it after rst asserts.
- seq_num and pc are opaque: no wrap or ordering checks.

Test Plan:
- Single pipe (pipe 0): pc=0x100, seq=3, waddr=1, wdata=2, wen=1.
  - Required: x_rdy[0]=1 in the same cycle.
  - Next cycle: rf_wen=1, rf_waddr=1, rf_wdata=2, cmp_val=1, cmp_seq_num=3.
- Contention with both pipes continuously valid for 4 cycles, pipe 0 seq 1,2 and pipe 1 seq 5,6.
  - Required grant order: 0,1,0,1.
  - Completions in order: seq 1,5,2,6.
  - Each message appears exactly once.
- x0 write: waddr=0, wdata=0xDEADBEEF, wen=1 -> rf_wen=0, cmp_val=1.
- wen=0 message: waddr=4, wdata=7 -> rf_wen=0, cmp_val=1, cmp_seq_num matches the message.
- Idle gaps: messages spaced 3 cycles apart -> cmp_val high for exactly one cycle per message; ptr unchanged across idle cycles.
- Reset mid-operation:
  - Assert rst asynchronously one cycle after a transfer (between edges) -> cmp_val and rf_wen drop immediately, and no completion is issued for that message.
  - After deassert, the first grant goes to pipe 0.
